sar_adc_spi_rx: RTL and testbench

//  Parametrised CNV/SCLK/SDO reader for AD798x-class SAR ADCs (3-wire, CS mode, no busy indicator).
//  NUM_CH converters share CNV and SCLK, each with its own SDO lane. Words are captured in parallel
//  and presented as one valid/ready output beat.

---
 rtl/sar_adc_spi_rx_if.sv | 11 +
 rtl/sar_adc_spi_rx.sv | 101 ++++++++++
 tb/tb_sar_adc_spi_rx.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sar_adc_spi_rx_if.sv
// sar_adc_spi_rx_if: valid/ready sample stream carrying all converter lanes in one beat
interface sar_adc_spi_rx_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 1
);
  logic [NUM_CH*DATA_WIDTH-1:0] m_data;
  logic                         m_valid;
  logic                         m_ready;
  modport master(output m_data, m_valid, input m_ready);
  modport slave(input m_data, m_valid, output m_ready);
endinterface

// File: rtl/sar_adc_spi_rx.sv
// sar_adc_spi_rx: CNV/SCLK/SDO reader for NUM_CH parallel AD798x-class SAR ADCs with valid/ready output
module sar_adc_spi_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CH      = 1,
  parameter int CONV_CYCLES = 70,
  parameter int SCLK_DIV    = 1,
  parameter int ACQ_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic              free_run,
  input  logic              trig,
  input  logic              overrun_clr,
  input  logic [NUM_CH-1:0] sdo,
  output logic              overrun,
  output logic              busy,
  output logic              cnv,
  output logic              sclk,
  sar_adc_spi_rx_if.master  m
);
  localparam int M1 = CONV_CYCLES > SCLK_DIV ? CONV_CYCLES : SCLK_DIV;
  localparam int M2 = M1 > ACQ_CYCLES ? M1 : ACQ_CYCLES;
  localparam int MX = M2 > DATA_WIDTH ? M2 : DATA_WIDTH;
  localparam int CW = $clog2(MX + 1);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CONVERT, READ, ACQ} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [BW-1:0] bits, bits_d;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] sh, sh_d;
  logic cnv_d, sclk_d, load, rise, valid_d, ovr_d;
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bits_d  = bits;
    cnv_d   = cnv;
    sclk_d  = sclk;
    load    = 1'b0;
    rise    = 1'b0;
    case (state)
      IDLE: if (free_run ? enable : trig) begin
        state_d = CONVERT;
        cnv_d   = 1'b1;
        cnt_d   = CW'(CONV_CYCLES - 1);
      end
      CONVERT: if (cnt == '0) begin
        state_d = READ;
        cnv_d   = 1'b0;
        sclk_d  = 1'b0;
        cnt_d   = CW'(SCLK_DIV - 1);
        bits_d  = '0;
      end else cnt_d = cnt - 1'b1;
      READ: if (cnt != '0) cnt_d = cnt - 1'b1;
      else begin
        cnt_d = CW'(SCLK_DIV - 1);
        if (!sclk) begin
          sclk_d = 1'b1;
          rise   = 1'b1;
          bits_d = bits + 1'b1;
        end else if (bits == BW'(DATA_WIDTH)) begin
          // sclk parks high; the would-be falling edge of the last period loads the output
          load    = 1'b1;
          state_d = ACQ_CYCLES == 0 ? IDLE : ACQ;
          cnt_d   = CW'(ACQ_CYCLES > 0 ? ACQ_CYCLES - 1 : 0);
        end else sclk_d = 1'b0;
      end
      ACQ: if (cnt == '0) state_d = IDLE; else cnt_d = cnt - 1'b1;
      default: state_d = IDLE;
    endcase
    for (int i = 0; i < NUM_CH; i++) sh_d[i] = rise ? DATA_WIDTH'({sh[i], sdo[i]}) : sh[i];
    valid_d = load | (m.m_valid & ~m.m_ready);
    // a fresh overrun beats a simultaneous clear
    ovr_d   = (load & m.m_valid & ~m.m_ready) | (overrun & ~overrun_clr);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      bits      <= '0;
      sh        <= '0;
      cnv       <= 1'b0;
      sclk      <= 1'b1;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      m.m_valid <= 1'b0;
      m.m_data  <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      bits      <= bits_d;
      sh        <= sh_d;
      cnv       <= cnv_d;
      sclk      <= sclk_d;
      busy      <= state_d != IDLE;
      overrun   <= ovr_d;
      m.m_valid <= valid_d;
      m.m_data  <= load ? sh : m.m_data;
    end
  end
endmodule

// File: tb/tb_sar_adc_spi_rx.sv
// tb_sar_adc_spi_rx: randomized scoreboard bench with a behavioural multi-lane ADC model
module tb_sar_adc_spi_rx;
  localparam int DW = 16, NC = 2, CC = 4, SD = 2, AC = 3;
  localparam int LOADLAT = CC + 2 * SD * DW;
  localparam int PERIOD  = 1 + LOADLAT + AC;
  logic clk = 0, rstn = 0, enable = 0, free_run = 0, trig = 0, overrun_clr = 0;
  logic [NC-1:0] sdo = '0;
  logic overrun, busy, cnv, sclk;
  sar_adc_spi_rx_if #(.DATA_WIDTH(DW), .NUM_CH(NC)) bus ();
  sar_adc_spi_rx #(.DATA_WIDTH(DW), .NUM_CH(NC), .CONV_CYCLES(CC), .SCLK_DIV(SD), .ACQ_CYCLES(AC)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .free_run(free_run), .trig(trig),
    .overrun_clr(overrun_clr), .sdo(sdo), .overrun(overrun), .busy(busy),
    .cnv(cnv), .sclk(sclk), .m(bus)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, cyc = 0, beats = 0;
  logic [NC*DW-1:0] adc_q[$], sb_q[$];
  int cnv_rise[$], sclk_rise[$];
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // ADC model: word latched at CNV rise, MSB shown first, next bit after every SCLK fall
  logic [NC*DW-1:0] cur = '0;
  int rises = 0, shown = 0;
  bit cnv_q = 0, sclk_q = 1;
  always @(cnv or sclk) begin
    if (cnv === 1'b1 && !cnv_q) begin
      cur = adc_q.size() > 0 ? adc_q.pop_front() : NC*DW'($urandom);
      rises = 0;
      shown = 0;
      cnv_rise.push_back(cyc);
    end
    if (sclk === 1'b1 && !sclk_q) begin
      rises++;
      sclk_rise.push_back(cyc);
    end
    if (sclk === 1'b0 && sclk_q) shown = rises;
    cnv_q = (cnv === 1'b1);
    sclk_q = (sclk !== 1'b0);
    for (int i = 0; i < NC; i++) sdo[i] = shown < DW ? cur[i*DW+DW-1-shown] : 1'b0;
  end
  always @(negedge clk) if (rstn && bus.m_valid && bus.m_ready) begin
    beats++;
    if (sb_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL beat: got %0h expected no beat (scoreboard empty)", bus.m_data);
    end else chk("beat data", bus.m_data, sb_q.pop_front());
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_trig();
    trig = 1;
    tick();
    trig = 0;
  endtask
  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: got busy=%b expected 0 within 300 cycles", nm, busy);
    end
  endtask
  function automatic int bad_gaps(input int q[$], input int gap);
    int b = 0;
    for (int i = 1; i < q.size(); i++) if (q[i] - q[i-1] != gap) b++;
    return b;
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [NC*DW-1:0] w;
    int n0, b0, n;
    bus.m_ready = 0;
    repeat (3) tick();
    chk("rst cnv", cnv, 0);
    chk("rst sclk", sclk, 1);
    chk("rst busy", busy, 0);
    chk("rst valid", bus.m_valid, 0);
    chk("rst data", bus.m_data, 0);
    chk("rst overrun", overrun, 0);
    rstn = 1;
    repeat (2) tick();
    chk("idle busy", busy, 0);
    // T1: exact timing of one triggered conversion
    w = 32'h1234_A5C3;
    adc_q.push_back(w);
    sb_q.push_back(w);
    sclk_rise.delete();
    pulse_trig();
    chk("t1 cnv start", cnv, 1);
    chk("t1 busy start", busy, 1);
    repeat (CC - 1) tick();
    chk("t1 cnv last", cnv, 1);
    tick();
    chk("t1 cnv fall", cnv, 0);
    chk("t1 sclk low", sclk, 0);
    repeat (LOADLAT - CC - 1) tick();
    chk("t1 valid early", bus.m_valid, 0);
    tick();
    chk("t1 valid", bus.m_valid, 1);
    chk("t1 data", bus.m_data, 32'h1234_A5C3);
    chk("t1 sclk park", sclk, 1);
    chk("t1 sclk rises", sclk_rise.size(), DW);
    chk("t1 sclk period", bad_gaps(sclk_rise, 2 * SD), 0);
    repeat (2) tick();
    chk("t1 busy acq", busy, 1);
    tick();
    chk("t1 busy end", busy, 0);
    bus.m_ready = 1;
    tick();
    bus.m_ready = 0;
    chk("t1 consumed", bus.m_valid, 0);
    // T2: overwrite with m_ready low
    adc_q.push_back(NC*DW'($urandom));
    adc_q.push_back({16'($urandom), 16'h0F0F});
    pulse_trig();
    wait_idle("t2 first");
    chk("t2 first valid", bus.m_valid, 1);
    chk("t2 first overrun", overrun, 0);
    pulse_trig();
    wait_idle("t2 second");
    chk("t2 valid", bus.m_valid, 1);
    chk("t2 lane0", bus.m_data[15:0], 16'h0F0F);
    chk("t2 overrun", overrun, 1);
    overrun_clr = 1;
    tick();
    overrun_clr = 0;
    chk("t2 overrun clr", overrun, 0);
    // set beats clear on the same edge
    w = NC*DW'($urandom);
    adc_q.push_back(w);
    sb_q.push_back(w);
    pulse_trig();
    repeat (LOADLAT - 1) tick();
    overrun_clr = 1;
    tick();
    overrun_clr = 0;
    chk("set wins", overrun, 1);
    chk("set wins data", bus.m_data, w);
    wait_idle("set wins");
    overrun_clr = 1;
    tick();
    overrun_clr = 0;
    // T3: consume old beat on the same edge as the new load
    w = NC*DW'($urandom);
    adc_q.push_back(w);
    sb_q.push_back(w);
    pulse_trig();
    repeat (LOADLAT - 1) tick();
    bus.m_ready = 1;
    tick();
    chk("t3 valid", bus.m_valid, 1);
    chk("t3 overrun", overrun, 0);
    chk("t3 data", bus.m_data, w);
    tick();
    chk("t3 drained", bus.m_valid, 0);
    wait_idle("t3");
    // T4: free running, then enable drop mid-read
    cnv_rise.delete();
    for (int i = 0; i < 5; i++) begin
      w = NC*DW'($urandom);
      adc_q.push_back(w);
      sb_q.push_back(w);
    end
    free_run = 1;
    enable = 1;
    n = 0;
    while (cnv_rise.size() < 5 && n < 600) begin
      tick();
      n++;
    end
    repeat (20) tick();
    enable = 0;
    wait_idle("t4");
    repeat (150) tick();
    free_run = 0;
    chk("t4 cnv count", cnv_rise.size(), 5);
    chk("t4 period", bad_gaps(cnv_rise, PERIOD), 0);
    chk("t4 drained", sb_q.size(), 0);
    // T5: asynchronous reset mid-read
    adc_q.push_back(NC*DW'($urandom));
    n0 = cnv_rise.size();
    pulse_trig();
    repeat (20) tick();
    chk("t5 in read", busy, 1);
    #3 rstn = 0;
    #1;
    chk("t5 cnv", cnv, 0);
    chk("t5 sclk", sclk, 1);
    chk("t5 valid", bus.m_valid, 0);
    chk("t5 busy", busy, 0);
    @(negedge clk) rstn = 1;
    repeat (10) tick();
    chk("t5 idle busy", busy, 0);
    chk("t5 no cnv", cnv_rise.size(), n0 + 1);
    // T6: triggers during CONVERT and ACQ are dropped
    w = NC*DW'($urandom);
    adc_q.push_back(w);
    sb_q.push_back(w);
    n0 = cnv_rise.size();
    b0 = beats;
    pulse_trig();
    repeat (2) tick();
    pulse_trig();
    repeat (LOADLAT - 3) tick();
    pulse_trig();
    chk("t6 busy acq", busy, 1);
    repeat (150) tick();
    chk("t6 one cnv", cnv_rise.size(), n0 + 1);
    chk("t6 one beat", beats, b0 + 1);
    chk("sb empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
